// File: rtl/spi_reg_bridge_pkg.sv
// Shared types and command encodings for the MCU SPI register bridge.
// Used by the frame decoder and by the write-pacing commit unit.
package spi_reg_bridge_pkg;

    localparam int         CMD_WRITE_BIT = 7;
    localparam logic [7:0] CMD_STATUS    = 8'h40;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR_HI,
        WR_LO,
        RD,
        SKIP
    } frame_state_t;

    typedef enum logic {
        COMMIT_READY,
        COMMIT_HOLD
    } commit_state_t;

    typedef struct packed {
        logic [3:0]  addr;
        logic [11:0] data;
    } reg_write_t;

endpackage

// File: rtl/spi_reg_commit.sv
// Write pacing unit: holds each presented register write for HOLD_CYCLES clocks
// so the slow consumer domain can see it, with one pending slot behind it.
module spi_reg_commit
    import spi_reg_bridge_pkg::*;
#(
    parameter int HOLD_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  reg_write_t  req,
    output logic [11:0] wr_reg,
    output logic [3:0]  wr_reg_addr,
    output logic        wr_reg_changed,
    output logic        overrun
);

    localparam int               CNT_W       = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);

    commit_state_t    state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    reg_write_t       out_reg, out_next;
    reg_write_t       pend_reg, pend_next;
    logic             pend_valid_reg, pend_valid_next;
    logic             changed_reg, changed_next;
    logic             overrun_reg, overrun_next;

    logic             present;
    reg_write_t       present_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= COMMIT_READY;
            count_reg      <= '0;
            out_reg        <= '0;
            pend_reg       <= '0;
            pend_valid_reg <= 1'b0;
            changed_reg    <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            out_reg        <= out_next;
            pend_reg       <= pend_next;
            pend_valid_reg <= pend_valid_next;
            changed_reg    <= changed_next;
            overrun_reg    <= overrun_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        out_next        = out_reg;
        pend_next       = pend_reg;
        pend_valid_next = pend_valid_reg;
        changed_next    = changed_reg;
        overrun_next    = overrun_reg;
        present         = 1'b0;
        present_val     = req;

        case (state_reg)
            COMMIT_READY: begin
                present = req_valid;
            end
            COMMIT_HOLD: begin
                if (count_reg == '0) begin
                    // Hold window over: the pending entry goes out and a
                    // simultaneous request takes the freed slot.
                    if (pend_valid_reg) begin
                        present         = 1'b1;
                        present_val     = pend_reg;
                        pend_valid_next = req_valid;
                        pend_next       = req;
                    end else begin
                        present = req_valid;
                    end
                end else begin
                    count_next = count_reg - 1'b1;
                    if (req_valid) begin
                        if (pend_valid_reg) begin
                            overrun_next = 1'b1;
                        end else begin
                            pend_valid_next = 1'b1;
                            pend_next       = req;
                        end
                    end
                end
            end
            default: state_next = COMMIT_READY;
        endcase

        if (present) begin
            out_next     = present_val;
            changed_next = ~changed_reg;
            count_next   = HOLD_RELOAD;
            state_next   = COMMIT_HOLD;
        end else if (state_reg == COMMIT_HOLD && count_reg == '0) begin
            state_next = COMMIT_READY;
        end
    end

    assign wr_reg         = out_reg.data;
    assign wr_reg_addr    = out_reg.addr;
    assign wr_reg_changed = changed_reg;
    assign overrun        = overrun_reg;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns MCU write frames into paced map_mux register
// writes and answers status-read frames with a snapshot of status_reg.
module spi_reg_bridge
    import spi_reg_bridge_pkg::*;
#(
    parameter int HOLD_CYCLES = 256,
    parameter int SYNC_STAGES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic [31:0] status_reg,
    output logic [11:0] wr_reg,
    output logic [3:0]  wr_reg_addr,
    output logic        wr_reg_changed,
    output logic        overrun
);

    // Bit 2 = sck, bit 1 = cs_n, bit 0 = mosi; all three share one pipeline
    // so mosi is aligned with the sck edge that samples it.
    logic [SYNC_STAGES-1:0][2:0] sync_reg;
    logic                        sck_prev_reg, cs_prev_reg;
    logic                        sck_s, cs_s, mosi_s;
    logic                        sck_rise, sck_fall, cs_fall, cs_rise;

    always_ff @(posedge clk) begin
        // cs_n history resets low so a frame already in progress is not
        // mistaken for a new one when reset releases.
        if (reset) begin
            sync_reg     <= '0;
            sck_prev_reg <= 1'b0;
            cs_prev_reg  <= 1'b0;
        end else begin
            sync_reg     <= {sync_reg[SYNC_STAGES-2:0], {spi_sck, spi_cs_n, spi_mosi}};
            sck_prev_reg <= sck_s;
            cs_prev_reg  <= cs_s;
        end
    end

    assign sck_s    = sync_reg[SYNC_STAGES-1][2];
    assign cs_s     = sync_reg[SYNC_STAGES-1][1];
    assign mosi_s   = sync_reg[SYNC_STAGES-1][0];
    assign sck_rise = sck_s & ~sck_prev_reg;
    assign sck_fall = ~sck_s & sck_prev_reg;
    assign cs_fall  = ~cs_s & cs_prev_reg;
    assign cs_rise  = cs_s & ~cs_prev_reg;

    frame_state_t state_reg, state_next;
    logic [4:0]   bit_cnt_reg, bit_cnt_next;
    logic [6:0]   shift_reg, shift_next;
    logic [3:0]   addr_reg, addr_next;
    logic [3:0]   data_hi_reg, data_hi_next;
    logic [31:0]  rd_shift_reg, rd_shift_next;
    logic [7:0]   byte_in;
    logic         req_valid;
    reg_write_t   req;

    assign byte_in = {shift_reg, mosi_s};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            addr_reg     <= '0;
            data_hi_reg  <= '0;
            rd_shift_reg <= '0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            addr_reg     <= addr_next;
            data_hi_reg  <= data_hi_next;
            rd_shift_reg <= rd_shift_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        addr_next     = addr_reg;
        data_hi_next  = data_hi_reg;
        rd_shift_next = rd_shift_reg;
        req_valid     = 1'b0;
        req.addr      = addr_reg;
        req.data      = {data_hi_reg, byte_in};

        if (cs_fall) begin
            state_next   = CMD;
            bit_cnt_next = '0;
        end else if (cs_rise) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                CMD, WR_HI, WR_LO: begin
                    if (sck_rise) begin
                        shift_next   = byte_in[6:0];
                        bit_cnt_next = bit_cnt_reg + 5'd1;
                        if (bit_cnt_reg == 5'd7) begin
                            bit_cnt_next = '0;
                            if (state_reg == CMD) begin
                                if (byte_in[CMD_WRITE_BIT] && byte_in[6:4] == 3'b000) begin
                                    addr_next  = byte_in[3:0];
                                    state_next = WR_HI;
                                end else if (byte_in == CMD_STATUS) begin
                                    rd_shift_next = status_reg;
                                    state_next    = RD;
                                end else begin
                                    state_next = SKIP;
                                end
                            end else if (state_reg == WR_HI) begin
                                data_hi_next = byte_in[3:0];
                                state_next   = WR_LO;
                            end else begin
                                req_valid  = 1'b1;
                                state_next = SKIP;
                            end
                        end
                    end
                end
                RD: begin
                    // The fall closing the command byte must not shift, so
                    // only falls after at least one RD rise advance the data.
                    if (sck_rise) begin
                        bit_cnt_next = bit_cnt_reg + 5'd1;
                        if (bit_cnt_reg == 5'd31) begin
                            bit_cnt_next = '0;
                            state_next   = SKIP;
                        end
                    end else if (sck_fall && bit_cnt_reg != 5'd0) begin
                        rd_shift_next = {rd_shift_reg[30:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign spi_miso = (state_reg == RD) && rd_shift_reg[31];

    spi_reg_commit #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_commit (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req            (req),
        .wr_reg         (wr_reg),
        .wr_reg_addr    (wr_reg_addr),
        .wr_reg_changed (wr_reg_changed),
        .overrun        (overrun)
    );

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- SPI slave between the board MCU and the mapper mux.
- Decodes MCU register-write frames into the wr_reg / wr_reg_addr / wr_reg_changed (toggle) interface that map_mux consumes.
- Serves status-read frames by shifting out a snapshot of map_mux's 32-bit status_reg.
- Paces writes so each presented value is held long enough for the slow M2-domain consumer, with a one-deep pending slot and overrun flag.

Parameters:
HOLD_CYCLES, 256, minimum clk cycles a presented write stays stable before the next may be presented (≥ 4 M2 periods at system clk)
SYNC_STAGES, 3, synchronizer depth for spi_sck / spi_cs_n / spi_mosi

Ports:
clk  in  1  system clock; all logic is on its rising edge
reset  in  1  synchronous, active-high reset
spi_sck  in  1  SPI clock, mode 0, asynchronous to clk; clk ≥ 8× sck
spi_cs_n  in  1  chip select, active low
spi_mosi  in  1  MCU→FPGA data, MSB first
spi_miso  out  1  FPGA→MCU data
status_reg  in  32  status word from map_mux
wr_reg  out  12  register data to map_mux
wr_reg_addr  out  4  register address to map_mux
wr_reg_changed  out  1  toggles once per presented write
overrun  out  1  sticky; a write was dropped

Behaviour:
- Inputs pass through SYNC_STAGES flops. Rise/fall of sck is detected on synced samples. MOSI is sampled on detected sck rise; MISO updates on detected sck fall.
- Frame starts on cs_n fall. It resets the bit counter and enters CMD.
- cs_n rise in any state returns to IDLE. A partial write is discarded with no output change.
- Frame FSM states: IDLE, CMD, WR_HI, WR_LO, RD, SKIP.
- CMD, after 8 bits:
  - byte[7]=1 and byte[6:4]=0 → write to addr byte[3:0]; go to WR_HI.
  - byte == 8'h40 → status read. Snapshot status_reg in that clk cycle; go to RD.
  - Any other byte → SKIP.
- WR_HI: byte = {4'bx, data[11:8]}; upper nibble is ignored.
- WR_LO: byte = data[7:0]. On its 8th bit, assert a one-cycle commit request {addr, data}, then go to SKIP.
- RD: shifts snapshot[31:0] MSB first across 4 bytes, then SKIP.
  - Bit 31 is driven on spi_miso within 2 clk of the CMD-completing sck rise, before the next sck rise.
- spi_miso is 0 in IDLE, CMD, WR_*, and SKIP. SKIP ignores all further bits until cs_n rises.
- Commit unit: states READY and HOLD; 1-entry pending slot; counter sized by $clog2(HOLD_CYCLES+1).
  - READY + request: on the next clk, load wr_reg / wr_reg_addr, toggle wr_reg_changed, counter = HOLD_CYCLES-1, go to HOLD.
  - HOLD + request, pending empty: store the request in pending.
  - HOLD + request, pending full: drop the request; set overrun=1.
  - HOLD, counter == 0, pending full: present pending (same 1-cycle load), clear the slot, reload counter, stay in HOLD.
  - HOLD, counter == 0, pending empty: go to READY.
  - A request in the same cycle the counter hits 0 with pending full: pending is presented, and the new request fills the freed slot. Nothing is dropped.
- wr_reg and wr_reg_addr change only in the same cycle as a wr_reg_changed toggle.
- Reset, any point mid-frame:
  - wr_reg=0, wr_reg_addr=0, wr_reg_changed=0, spi_miso=0, overrun=0.
  - FSM to IDLE, commit unit to READY, pending cleared.
  - A frame in progress is ignored until the next cs_n fall.
- overrun clears only on reset.

Decomposition:
- Package spi_reg_bridge_pkg:
  - CMD_WRITE_BIT (7), CMD_STATUS (8'h40).
  - Enum frame_state_t {IDLE, CMD, WR_HI, WR_LO, RD, SKIP}.
  - Struct reg_write_t {addr[3:0], data[11:0]}.
- Sub-module spi_reg_commit: HOLD/pending pacing unit. Input is a reg_write_t request strobe; outputs are wr_reg, wr_reg_addr, wr_reg_changed, overrun.
- The synchronizers and frame FSM stay in the top.

Test Plan:
- Write frame 8'h80, 8'h0A, 8'h5C → wr_reg=12'hA5C, wr_reg_addr=0, wr_reg_changed 0→1 exactly once, ≤ 2 clk after the last sck rise synced.
- Three back-to-back writes (addr 0/1/2, data 1/2/3), with frame 2 completing 10 clk after frame 1 → 2nd presented exactly HOLD_CYCLES after the 1st. 3rd dropped, overrun=1, wr_reg_changed toggles exactly twice.
- Status read: status_reg=32'hDEADBEEF, send 8'h40 then 4 dummy bytes → MISO returns DE AD BE EF. Changing status_reg mid-shift does not alter the output.
- cs_n rises after WR_HI (8'h83, 8'h07 only) → no toggle, outputs unchanged. Next full frame to addr 1 is presented normally.
- Invalid command 8'h90 plus 2 bytes → no toggle, MISO 0 throughout. Extra bytes after a valid write → single toggle only.
- Reset asserted while in HOLD with pending full → all outputs 0, no further toggle; a new write then presents immediately (READY path).
